stopwatch_uart_reporter: RTL and testbench
==========================================

Name: stopwatch_uart_reporter

Overview:
- Downstream consumer of the stopwatch datapath outputs: msec (centiseconds), sec, min and hour.
- On a report request it snapshots the four counters and converts them to ASCII.
- It then streams the frame "HH:MM:SS.CC\r\n" one byte at a time to the UART transmitter over a valid/ready handshake.
- This lets the PC side log stopwatch time.

Parameters:
- SEND_CRLF, 1, 1: frame ends with 8'h0D 8'h0A (13 bytes); 0: frame ends after CC (11 bytes).

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block
- i_msec  input  7  centisecond count, 0..99
- i_sec  input  6  second count, 0..59
- i_min  input  6  minute count, 0..59
- i_hour  input  5  hour count, 0..23
- i_report  input  1  report request, sampled every cycle (level or pulse; each high cycle is a request)
- i_tx_ready  input  1  UART TX can accept a byte this cycle
- o_tx_data  output  8  ASCII byte offered to the UART TX
- o_tx_valid  output  1  o_tx_data is valid
- o_busy  output  1  a frame is in progress
- o_done  output  1  one-cycle pulse after the last byte of a frame is accepted

Behaviour:
- Reset values: o_tx_data=8'h00, o_tx_valid=0, o_busy=0, o_done=0, internal pending flag=0, byte index=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately. No further bytes are sent and no o_done is pulsed.
- FSM states: IDLE, SEND.
- IDLE, i_report=1 at edge N:
  - Register the clamped snapshot of i_hour/i_min/i_sec/i_msec at edge N.
  - Set index=0 and go to SEND.
  - From cycle N+1: o_busy=1, o_tx_valid=1, o_tx_data = first byte.
- Clamping (applied at snapshot): msec>99 becomes 99; sec>59 becomes 59; min>59 becomes 59; hour>23 becomes 23.
- Digit conversion: tens = v/10, ones = v%10, each encoded as 8'h30+digit. Valid for v ≤ 99.
- Byte order: H-tens, H-ones, ':'(8'h3A), M-tens, M-ones, ':', S-tens, S-ones, '.'(8'h2E), C-tens, C-ones, then 8'h0D, 8'h0A if SEND_CRLF=1.
- Hours always print two digits with a leading '0'.
- Handshake:
  - A byte transfers on an edge with o_tx_valid&&i_tx_ready.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data and the index hold unchanged.
  - o_tx_valid is never dropped mid-frame.
  - On transfer, index advances and the next byte is presented the following cycle, giving back-to-back bytes when i_tx_ready stays high.
- Frame end:
  - On transfer of the last byte (index 12, or 10 if SEND_CRLF=0), pulse o_done=1 for the next cycle.
  - If pending=0: go to IDLE, o_tx_valid=0, o_busy=0.
  - If pending=1: clear pending, take a fresh snapshot at that same edge, reset index=0, stay in SEND. o_tx_valid stays 1 and o_busy stays 1 with no gap; o_done still pulses.
- Request during SEND sets pending=1. Multiple requests within one frame collapse to a single pending request.
- A request on the same edge as the last-byte transfer counts as pending and starts the next frame.
- The snapshot is never updated mid-frame. Counter changes during a frame do not alter bytes already queued.
- The block never inspects i_tx_ready in IDLE.

Test Plan:
- Basic frame: hour=12, min=34, sec=56, msec=78, pulse i_report, i_tx_ready=1 → from the next cycle 13 consecutive bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A. o_done pulses once after 0A, then o_busy=0.
- Backpressure: 01:02:03.04, i_tx_ready toggled 1-0-0-1 pattern → o_tx_data and o_tx_valid hold during ready=0. Byte sequence is exactly 30 31 3A 30 32 3A 30 33 2E 30 34 0D 0A with no drops or duplicates.
- Clamp and snapshot: inputs msec=127, sec=63, min=60, hour=31 at request, then inputs changed mid-frame → frame is "23:59:59.99\r\n". Later input changes do not appear.
- Request while busy: three i_report pulses during frame 1, inputs changed to 00:00:01.00 before frame 1 ends → exactly one extra frame "00:00:01.00\r\n" (values sampled at frame-1 last-byte edge), starting with no idle gap. o_done pulses twice.
- Reset mid-frame: reset=0 for one edge after byte 5 → next cycle o_tx_valid=0, o_busy=0, o_tx_data=00, no o_done. A later request yields a complete fresh frame.
- SEND_CRLF=0: 00:00:00.00 request → 11 bytes 30 30 3A 30 30 3A 30 30 2E 30 30, o_done after the final 30.

Source files
------------

// File: rtl/stopwatch_uart_reporter.sv
// Snapshots the stopwatch counters on request and streams "HH:MM:SS.CC[\r\n]"
// as ASCII bytes over a valid/ready handshake to a UART transmitter.
module stopwatch_uart_reporter #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_report,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_busy,
  output logic       o_done
);
  localparam logic [3:0] LAST = SEND_CRLF ? 4'd12 : 4'd10;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic       pending, pending_n;
  logic       load, done_n;
  logic [6:0] hh, mm, ss, cc;
  logic [15:0] h_a, m_a, s_a, c_a;

  function automatic logic [15:0] ascii2(input logic [6:0] v);
    logic [3:0] t, o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {4'h3, t, 4'h3, o};
  endfunction

  assign h_a = ascii2(hh);
  assign m_a = ascii2(mm);
  assign s_a = ascii2(ss);
  assign c_a = ascii2(cc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      o_done  <= 1'b0;
      hh <= '0; mm <= '0; ss <= '0; cc <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      o_done  <= done_n;
      if (load) begin
        // clamp at capture so the digit encoder only ever sees 0..99
        hh <= (i_hour > 5'd23) ? 7'd23 : {2'b00, i_hour};
        mm <= (i_min  > 6'd59) ? 7'd59 : {1'b0, i_min};
        ss <= (i_sec  > 6'd59) ? 7'd59 : {1'b0, i_sec};
        cc <= (i_msec > 7'd99) ? 7'd99 : i_msec;
      end
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    load      = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: if (i_report) begin
        load    = 1'b1;
        idx_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (i_report) pending_n = 1'b1;
        if (i_tx_ready) begin
          if (idx == LAST) begin
            done_n    = 1'b1;
            pending_n = 1'b0;
            // a request landing on the final transfer edge still chains
            if (pending || i_report) begin
              load  = 1'b1;
              idx_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_tx_data = 8'h00;
    if (state == SEND) begin
      case (idx)
        4'd0:  o_tx_data = h_a[15:8];
        4'd1:  o_tx_data = h_a[7:0];
        4'd2:  o_tx_data = 8'h3A;
        4'd3:  o_tx_data = m_a[15:8];
        4'd4:  o_tx_data = m_a[7:0];
        4'd5:  o_tx_data = 8'h3A;
        4'd6:  o_tx_data = s_a[15:8];
        4'd7:  o_tx_data = s_a[7:0];
        4'd8:  o_tx_data = 8'h2E;
        4'd9:  o_tx_data = c_a[15:8];
        4'd10: o_tx_data = c_a[7:0];
        4'd11: o_tx_data = 8'h0D;
        4'd12: o_tx_data = 8'h0A;
        default: o_tx_data = 8'h00;
      endcase
    end
  end

  assign o_tx_valid = (state == SEND);
  assign o_busy     = (state == SEND);
endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Drives both frame variants with shared stimulus and compares every cycle
// against a queue-of-expected-bytes model built from formatted time strings.
module tb_stopwatch_uart_reporter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       report, tx_ready;
  logic [7:0] data  [2];
  logic       valid [2];
  logic       busy  [2];
  logic       done  [2];

  stopwatch_uart_reporter #(.SEND_CRLF(1'b1)) dut_crlf (
    .clk(clk), .reset(reset), .i_msec(msec), .i_sec(sec), .i_min(min), .i_hour(hour),
    .i_report(report), .i_tx_ready(tx_ready), .o_tx_data(data[0]),
    .o_tx_valid(valid[0]), .o_busy(busy[0]), .o_done(done[0]));

  stopwatch_uart_reporter #(.SEND_CRLF(1'b0)) dut_nocr (
    .clk(clk), .reset(reset), .i_msec(msec), .i_sec(sec), .i_min(min), .i_hour(hour),
    .i_report(report), .i_tx_ready(tx_ready), .o_tx_data(data[1]),
    .o_tx_valid(valid[1]), .o_busy(busy[1]), .o_done(done[1]));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: per instance, the bytes still owed plus busy/pending flags
  logic [7:0] q [2][$];
  bit m_busy [2];
  bit m_pend [2];
  bit m_done [2];
  int frames [2];

  function automatic void push_frame(int k);
    int h, m, s, c;
    string f;
    h = (hour > 23) ? 23 : int'(hour);
    m = (min  > 59) ? 59 : int'(min);
    s = (sec  > 59) ? 59 : int'(sec);
    c = (msec > 99) ? 99 : int'(msec);
    f = $sformatf("%02d:%02d:%02d.%02d", h, m, s, c);
    for (int i = 0; i < f.len(); i++) q[k].push_back(f[i]);
    if (k == 0) begin
      q[k].push_back(8'h0D);
      q[k].push_back(8'h0A);
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit nd;
      chk($sformatf("busy%0d", k),  32'(busy[k]),  32'(m_busy[k]));
      chk($sformatf("valid%0d", k), 32'(valid[k]), 32'(m_busy[k]));
      chk($sformatf("done%0d", k),  32'(done[k]),  32'(m_done[k]));
      if (m_busy[k] && q[k].size() > 0)
        chk($sformatf("data%0d", k), 32'(data[k]), 32'(q[k][0]));
      else
        chk($sformatf("idle_data%0d", k), 32'(data[k]), 32'h0);
      nd = 1'b0;
      if (!reset) begin
        m_busy[k] = 1'b0;
        m_pend[k] = 1'b0;
        q[k].delete();
      end else if (m_busy[k]) begin
        if (report) m_pend[k] = 1'b1;
        if (tx_ready && q[k].size() > 0) begin
          void'(q[k].pop_front());
          if (q[k].size() == 0) begin
            nd = 1'b1;
            frames[k]++;
            if (m_pend[k]) begin
              m_pend[k] = 1'b0;
              push_frame(k);
            end else begin
              m_busy[k] = 1'b0;
            end
          end
        end
      end else if (report) begin
        push_frame(k);
        m_busy[k] = 1'b1;
      end
      m_done[k] = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t(input int h, input int m, input int s, input int c);
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
  endtask

  initial begin
    report = 1'b0; tx_ready = 1'b1; set_t(0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // basic frame
    set_t(12, 34, 56, 78); report = 1'b1; step(); report = 1'b0;
    repeat (18) step();

    // backpressure 1-0-0-1
    set_t(1, 2, 3, 4); report = 1'b1; step(); report = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tx_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    tx_ready = 1'b1;
    repeat (4) step();

    // clamp, then scribble the inputs mid-frame
    set_t(31, 60, 63, 127); report = 1'b1; step(); report = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hour = 5'($urandom); min = 6'($urandom); sec = 6'($urandom); msec = 7'($urandom);
      step();
    end

    // requests while busy collapse into one follow-on frame
    set_t(5, 6, 7, 8); report = 1'b1; step(); report = 1'b0;
    for (int i = 0; i < 12; i++) begin
      report = (i == 2) || (i == 4) || (i == 6);
      if (i == 8) set_t(0, 0, 1, 0);
      step();
    end
    report = 1'b0;
    repeat (20) step();

    // reset mid-frame, then a clean frame
    set_t(9, 8, 7, 6); report = 1'b1; step(); report = 1'b0;
    repeat (6) step();
    reset = 1'b0; step(); reset = 1'b1;
    repeat (4) step();
    set_t(0, 0, 0, 0); report = 1'b1; step(); report = 1'b0;
    repeat (16) step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      hour = 5'($urandom); min = 6'($urandom); sec = 6'($urandom); msec = 7'($urandom);
      report   = ($urandom_range(0, 19) == 0);
      tx_ready = ($urandom_range(0, 9) < 7);
      reset    = ($urandom_range(0, 499) != 0);
      step();
    end
    reset = 1'b1; report = 1'b0; tx_ready = 1'b1;
    repeat (40) step();

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("drained%0d", k), 32'(q[k].size()), 32'h0);
      chk($sformatf("frames_seen%0d", k), 32'(frames[k] > 10), 32'h1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
